router_pkt_fifo: RTL and testbench
==================================

# router_pkt_fifo

Parametrised, packet-aware synchronous FIFO for the router output channels. It replaces the fixed 16x8 channel FIFO. Each stored word carries a header flag, and the read side tracks packet length from the header byte. The block sits between the router register block (write side) and each output port's read interface (read side). Compared with the fixed FIFO, it adds an almost-full threshold, a sticky overflow flag, a packet-done strobe and a synthesizable idle output.

## Interface
Parameters:
- DATA_W, 8, data word width; must be at least LEN_LSB+2.
- DEPTH, 16, number of entries; must be a power of 2 and at least 4. AW = log2(DEPTH).
- LEN_LSB, 2, LSB of the header length field, which occupies data[DATA_W-1:LEN_LSB].
- AFULL_TH, DEPTH-2, occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset, synchronous, active-low.
- soft_rst  in  1  synchronous channel flush; same effect as rstn.
- wr_enb  in  1  write request.
- lfd_state  in  1  marks data_in as a packet header byte.
- data_in  in  DATA_W  write data.
- rd_enb  in  1  read request.
- data_out  out  DATA_W  registered read data.
- full  out  1  no free entry.
- empty  out  1  no stored entry.
- almost_full  out  1  occupancy >= AFULL_TH.
- pkt_done  out  1  one-cycle strobe while data_out shows the last byte of a packet.
- overflow_err  out  1  sticky flag: a write was attempted while full.
- occupancy  out  AW+1  entries stored; this port exists only under ROUTER_PKT_FIFO_OCC_EN.

## Operation
- Storage: DEPTH words of DATA_W+1 bits, {hdr_flag, data}. Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are AW+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ) and (low AW bits equal).
- Write is accepted when wr_enb && !full. The word {lfd_state, data_in} is stored at wr_ptr[AW-1:0], then wr_ptr increments.
- Write with full is dropped, and overflow_err is set. overflow_err is cleared only by rstn or soft_rst.
- Read is accepted when rd_enb && !empty. data_out <= mem[rd_ptr], then rd_ptr increments.
- Read with empty is ignored and has no other effect.
- Packet counter pkt_cnt, width DATA_W-LEN_LSB+1, updated on each accepted read:
  - Header word: pkt_cnt <= len+1, where len = data[DATA_W-1:LEN_LSB] (payload bytes plus parity byte).
  - Non-header word with pkt_cnt != 0: pkt_cnt <= pkt_cnt-1. If pkt_cnt was 1, pkt_done <= 1 for one cycle.
  - Non-header word with pkt_cnt == 0: pkt_cnt stays 0, no strobe.
- Idle output: in a cycle with pkt_cnt == 0 and no accepted read, data_out <= 0. A high-Z idle value is not used.
- Simultaneous accepted read and write: both pointers move and occupancy is unchanged.
  - When full, only the read is accepted; the write is dropped.
  - When empty, only the write is accepted.
- Reset (rstn low or soft_rst high) at a clock edge clears both pointers, pkt_cnt, data_out, pkt_done and overflow_err. This applies mid-packet; any partial packet is discarded.
- Reset values: data_out=0, empty=1, full=0, almost_full=0, pkt_done=0, overflow_err=0, occupancy=0.

## Timing
- full, empty and almost_full are combinational from the registered pointers. They are valid in the same cycle and reflect a write or read one cycle after the accepting edge.
- Read latency is 1 cycle: data_out is valid in the cycle after the rd_enb edge.
- pkt_done is registered and aligned with the data_out of the packet's last byte.
- No bypass: a word written at edge N can be read at edge N+1 at the earliest, and appears on data_out after edge N+1.
- Pointer arithmetic is modulo 2^(AW+1). Wrap-around needs no special case.

## Configuration
- ROUTER_PKT_FIFO_OCC_EN defined: the occupancy port exists and carries wr_ptr - rd_ptr, range 0..DEPTH, combinational from the pointers.
- ROUTER_PKT_FIFO_OCC_EN undefined: the port is absent. almost_full uses an internal difference computation, and its behaviour is otherwise identical.

## Structure
- Shared package router_pkg holds:
  - default DATA_W and LEN_LSB;
  - the HDR_FLAG bit index (DATA_W);
  - the header length-field extraction function.
- One sub-module, router_fifo_ptr, contains pointer registers, full/empty/almost_full generation and occupancy. The top module holds the memory, the packet counter and the output register.

## Test plan
Default parameters unless noted.
- Reset: hold rstn=0 for 2 cycles, then release -> data_out=0, empty=1, full=0, pkt_done=0, overflow_err=0.
- Single packet:
  - Write header 8'h0D (lfd=1, len=3), then 8'h11, 8'h22, 8'h33, parity 8'h3F.
  - Read 5 back-to-back -> data_out = 0D, 11, 22, 33, 3F, one cycle after each read.
  - pkt_done=1 only with 3F; data_out=0 the following idle cycle.
- Fill and overflow:
  - 14 writes -> almost_full=1.
  - 16 writes -> full=1.
  - 17th write (8'hAA) dropped -> overflow_err=1.
  - 16 reads return the data in order; AA never appears.
- Wrap: two rounds of 10 writes then 10 reads (pointers cross DEPTH) -> all data intact; empty=1 and occupancy=0 at the end.
- Full with simultaneous rd_enb=wr_enb=1 -> read accepted, write dropped, occupancy 15 next cycle. Empty with both high -> write accepted, data_out unchanged.
- soft_rst pulse after the header and 1 payload byte have been read -> next cycle empty=1, pkt_cnt=0, data_out=0, overflow_err=0; a following packet reads correctly.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: default widths, header flag position and the
// header length-field extraction used by the packet FIFO.
package router_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LEN_LSB = 2;

  // The header flag is stored one bit above the data word.
  function automatic int hdr_flag_idx(input int data_w);
    return data_w;
  endfunction

  localparam int HDR_FLAG = hdr_flag_idx(DEF_DATA_W);

  // Length field is data[DATA_W-1:LEN_LSB]; the caller truncates to its width.
  function automatic logic [31:0] hdr_len(input logic [31:0] word, input int len_lsb);
    return word >> len_lsb;
  endfunction

endpackage

// File: rtl/router_fifo_ptr.sv
// Pointer block for router_pkt_fifo: wrap-bit pointers, full/empty/almost_full
// and, under ROUTER_PKT_FIFO_OCC_EN, the occupancy output.
module router_fifo_ptr #(
  parameter  int DEPTH    = 16,
  parameter  int AFULL_TH = DEPTH - 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          soft_rst,
  input  logic          wr_enb,
  input  logic          rd_enb,
  output logic          wr_acc,
  output logic          rd_acc,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic          full,
  output logic          empty,
  output logic          almost_full
`ifdef ROUTER_PKT_FIFO_OCC_EN
  ,
  output logic [AW:0]   occupancy
`endif
);
  import router_pkg::*;

  localparam logic [AW:0] AFULL_V = AFULL_TH[AW:0];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] occ;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Modulo subtraction stays correct across the wrap bit.
  assign occ         = wr_ptr_q - rd_ptr_q;
  assign almost_full = (occ >= AFULL_V);

  assign wr_acc  = wr_enb && !full;
  assign rd_acc  = rd_enb && !empty;
  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

`ifdef ROUTER_PKT_FIFO_OCC_EN
  assign occupancy = occ;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_acc};
  end

  always_ff @(posedge clk) begin
    if (!rstn || soft_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware router output FIFO: header-flagged storage, packet length
// tracking with pkt_done strobe. Optional occupancy port: ROUTER_PKT_FIFO_OCC_EN.
module router_pkt_fifo import router_pkg::*; #(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int DEPTH    = 16,
  parameter  int LEN_LSB  = DEF_LEN_LSB,
  parameter  int AFULL_TH = DEPTH - 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              soft_rst,
  input  logic              wr_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              pkt_done,
  output logic              overflow_err
`ifdef ROUTER_PKT_FIFO_OCC_EN
  ,
  output logic [AW:0]       occupancy
`endif
);

  localparam int LW      = DATA_W - LEN_LSB;
  localparam int CW      = LW + 1;
  localparam int HDR_IDX = hdr_flag_idx(DATA_W);

  logic          wr_acc, rd_acc;
  logic [AW-1:0] wr_addr, rd_addr;

  router_fifo_ptr #(
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH)
  ) u_ptr (
    .clk         (clk),
    .rstn        (rstn),
    .soft_rst    (soft_rst),
    .wr_enb      (wr_enb),
    .rd_enb      (rd_enb),
    .wr_acc      (wr_acc),
    .rd_acc      (rd_acc),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
`ifdef ROUTER_PKT_FIFO_OCC_EN
    ,
    .occupancy   (occupancy)
`endif
  );

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DATA_W:0]   rd_word;
  logic [LW-1:0]     rd_len;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [CW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic              pkt_done_q, pkt_done_d;
  logic              overflow_q, overflow_d;

  // Storage is not reset; only pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_addr] <= {lfd_state, data_in};
  end

  assign rd_word = mem_q[rd_addr];
  assign rd_len  = LW'(hdr_len(32'(rd_word[DATA_W-1:0]), LEN_LSB));

  always_comb begin
    data_out_d = data_out_q;
    pkt_cnt_d  = pkt_cnt_q;
    pkt_done_d = 1'b0;
    overflow_d = overflow_q || (wr_enb && full);
    if (rd_acc) begin
      data_out_d = rd_word[DATA_W-1:0];
      if (rd_word[HDR_IDX]) begin
        // Header length counts payload plus the trailing parity byte.
        pkt_cnt_d = {1'b0, rd_len} + CW'(1);
      end else if (pkt_cnt_q != '0) begin
        pkt_cnt_d  = pkt_cnt_q - CW'(1);
        pkt_done_d = (pkt_cnt_q == CW'(1));
      end
    end else if (pkt_cnt_q == '0) begin
      data_out_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || soft_rst) begin
      data_out_q <= '0;
      pkt_cnt_q  <= '0;
      pkt_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pkt_done_q <= pkt_done_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_out     = data_out_q;
  assign pkt_done     = pkt_done_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo against a queue-based packet model.
module tb_router_pkt_fifo;

  localparam int DEPTH = 16;
  localparam int AFTH  = 14;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       soft_rst = 1'b0;
  logic       wr_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = '0;
  logic       rd_enb = 1'b0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, pkt_done, overflow_err;
`ifdef ROUTER_PKT_FIFO_OCC_EN
  logic [4:0] occupancy;
`endif

  always #5 clk = ~clk;

  router_pkt_fifo #(
    .DATA_W(8), .DEPTH(DEPTH), .LEN_LSB(2), .AFULL_TH(AFTH)
  ) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .soft_rst     (soft_rst),
    .wr_enb       (wr_enb),
    .lfd_state    (lfd_state),
    .data_in      (data_in),
    .rd_enb       (rd_enb),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .pkt_done     (pkt_done),
    .overflow_err (overflow_err)
`ifdef ROUTER_PKT_FIFO_OCC_EN
    ,
    .occupancy    (occupancy)
`endif
  );

  // Reference model: a queue of {hdr, data} words plus packet bookkeeping.
  logic [8:0] mq[$];
  logic [7:0] m_dout = '0;
  logic       m_done = 1'b0;
  logic       m_ovf  = 1'b0;
  int         m_cnt  = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic step(input logic wr, input logic lfd, input logic [7:0] din,
                      input logic rd, input logic rn, input logic srst);
    logic       was_full, was_empty;
    logic [8:0] w;
    wr_enb = wr; lfd_state = lfd; data_in = din; rd_enb = rd;
    rstn = rn; soft_rst = srst;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    @(posedge clk);
    if (!rn || srst) begin
      mq.delete(); m_dout = '0; m_done = 1'b0; m_ovf = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (wr && was_full) m_ovf = 1'b1;
      if (rd && !was_empty) begin
        w = mq.pop_front();
        m_dout = w[7:0];
        if (w[8]) m_cnt = int'(w[7:2]) + 1;
        else if (m_cnt > 0) begin
          m_done = (m_cnt == 1);
          m_cnt--;
        end
      end else if (m_cnt == 0) begin
        m_dout = '0;
      end
      if (wr && !was_full) mq.push_back({lfd, din});
    end
    #1;
    wr_enb = 1'b0; rd_enb = 1'b0; lfd_state = 1'b0; soft_rst = 1'b0;
  endtask

  task automatic do_reset();
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 0, 1, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", data_out); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b want 0", almost_full); end
    n_cmp++; if (pkt_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", pkt_done); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow_err); end
`ifdef ROUTER_PKT_FIFO_OCC_EN
    n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
`endif
  endtask

  task automatic test_single_packet();
    logic [7:0] pk [5];
    pk[0] = 8'h0D; pk[1] = 8'h11; pk[2] = 8'h22; pk[3] = 8'h33; pk[4] = 8'h3F;
    do_reset();
    for (int i = 0; i < 5; i++) step(1, (i == 0), pk[i], 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'h00, 1, 1, 0);
      n_cmp++; if (data_out !== pk[i] || data_out !== m_dout) begin n_err++; $display("FAIL pkt_dout[%0d]: got %h want %h", i, data_out, pk[i]); end
      n_cmp++; if (pkt_done !== (i == 4)) begin n_err++; $display("FAIL pkt_done[%0d]: got %b want %b", i, pkt_done, (i == 4)); end
    end
    step(0, 0, 8'h00, 0, 1, 0);
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL pkt_idle_dout: got %h want 00", data_out); end
    n_cmp++; if (pkt_done !== 1'b0) begin n_err++; $display("FAIL pkt_idle_done: got %b want 0", pkt_done); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, 8'($urandom_range(0, 127)), 0, 1, 0);
      n_cmp++; if (almost_full !== (i >= AFTH)) begin n_err++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, (i >= AFTH)); end
      n_cmp++; if (full !== (i == DEPTH)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == DEPTH)); end
    end
    step(1, 0, 8'hAA, 0, 1, 0);
    n_cmp++; if (overflow_err !== 1'b1 || m_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow_err); end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", full); end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 8'h00, 1, 1, 0);
      n_cmp++; if (data_out !== m_dout || data_out === 8'hAA) begin n_err++; $display("FAIL drain_dout[%0d]: got %h want %h", i, data_out, m_dout); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty); end
    n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom), 0, 1, 0);
      for (int i = 0; i < 10; i++) begin
        step(0, 0, 8'h00, 1, 1, 0);
        n_cmp++; if (data_out !== m_dout) begin n_err++; $display("FAIL wrap_dout[%0d.%0d]: got %h want %h", r, i, data_out, m_dout); end
      end
    end
    step(0, 0, 8'h00, 0, 1, 0);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", empty); end
`ifdef ROUTER_PKT_FIFO_OCC_EN
    n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL wrap_occ: got %0d want 0", occupancy); end
`endif
  endtask

  task automatic test_simultaneous();
    logic [7:0] keep;
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'($urandom), 0, 1, 0);
    step(1, 0, 8'h55, 1, 1, 0);
    n_cmp++; if (data_out !== m_dout) begin n_err++; $display("FAIL sim_full_dout: got %h want %h", data_out, m_dout); end
    n_cmp++; if (full !== 1'b0 || mq.size() != DEPTH - 1) begin n_err++; $display("FAIL sim_full_flag: got %b want 0", full); end
`ifdef ROUTER_PKT_FIFO_OCC_EN
    n_cmp++; if (occupancy !== 5'(DEPTH - 1)) begin n_err++; $display("FAIL sim_full_occ: got %0d want %0d", occupancy, DEPTH - 1); end
`endif
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 8'h00, 1, 1, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    keep = data_out;
    step(1, 0, 8'h6B, 1, 1, 0);
    n_cmp++; if (data_out !== keep || data_out !== m_dout) begin n_err++; $display("FAIL sim_empty_dout: got %h want %h", data_out, m_dout); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL sim_empty_flag: got %b want 0", empty); end
    step(0, 0, 8'h00, 1, 1, 0);
    n_cmp++; if (data_out !== 8'h6B) begin n_err++; $display("FAIL sim_empty_read: got %h want 6b", data_out); end
  endtask

  task automatic test_soft_rst();
    logic [5:0] len;
    do_reset();
    step(1, 1, 8'h0D, 0, 1, 0);
    for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 8'($urandom), 0, 1, 0);
    step(1, 0, 8'hAA, 0, 1, 0);
    step(0, 0, 8'h00, 1, 1, 0);
    step(0, 0, 8'h00, 1, 1, 0);
    step(0, 0, 8'h00, 0, 1, 1);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL srst_empty: got %b want 1", empty); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL srst_dout: got %h want 00", data_out); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL srst_ovf: got %b want 0", overflow_err); end
    n_cmp++; if (u_dut.pkt_cnt_q !== '0) begin n_err++; $display("FAIL srst_pkt_cnt: got %0d want 0", u_dut.pkt_cnt_q); end
    len = 6'($urandom_range(1, 6));
    step(1, 1, {len, 2'b01}, 0, 1, 0);
    for (int i = 0; i <= int'(len); i++) step(1, 0, 8'($urandom), 0, 1, 0);
    for (int i = 0; i <= int'(len) + 1; i++) begin
      step(0, 0, 8'h00, 1, 1, 0);
      n_cmp++; if (data_out !== m_dout) begin n_err++; $display("FAIL srst_pkt_dout[%0d]: got %h want %h", i, data_out, m_dout); end
      n_cmp++; if (pkt_done !== (i == int'(len) + 1)) begin n_err++; $display("FAIL srst_pkt_done[%0d]: got %b want %b", i, pkt_done, (i == int'(len) + 1)); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 8'($urandom),
           1'($urandom_range(0, 1)), 1, ($urandom_range(0, 99) == 0));
      n_cmp++; if (data_out !== m_dout) begin n_err++; $display("FAIL rnd_dout[%0d]: got %h want %h", c, data_out, m_dout); end
      n_cmp++; if (pkt_done !== m_done) begin n_err++; $display("FAIL rnd_done[%0d]: got %b want %b", c, pkt_done, m_done); end
      n_cmp++; if (empty !== (mq.size() == 0)) begin n_err++; $display("FAIL rnd_empty[%0d]: got %b want %b", c, empty, (mq.size() == 0)); end
      n_cmp++; if (full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full[%0d]: got %b want %b", c, full, (mq.size() == DEPTH)); end
      n_cmp++; if (almost_full !== (mq.size() >= AFTH)) begin n_err++; $display("FAIL rnd_afull[%0d]: got %b want %b", c, almost_full, (mq.size() >= AFTH)); end
      n_cmp++; if (overflow_err !== m_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d]: got %b want %b", c, overflow_err, m_ovf); end
`ifdef ROUTER_PKT_FIFO_OCC_EN
      n_cmp++; if (occupancy !== 5'(mq.size())) begin n_err++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", c, occupancy, mq.size()); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_fill_overflow();
    test_wrap();
    test_simultaneous();
    test_soft_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
